// File: rtl/uc_seq_pkg.sv
// Shared encodings and microword field layout for the uc_sequencer microprogram control unit.
// Word layout, MSB first: src[2] | op[3] | pol | csel[CSEL_W] | ctrl[CTRL_W] | literal[ADDR_W].
package uc_seq_pkg;

  localparam logic [2:0] UC_CONT = 3'd0;
  localparam logic [2:0] UC_JUMP = 3'd1;
  localparam logic [2:0] UC_CALL = 3'd2;
  localparam logic [2:0] UC_RET  = 3'd3;
  localparam logic [2:0] UC_LDCT = 3'd4;
  localparam logic [2:0] UC_LOOP = 3'd5;

  localparam logic [1:0] UC_SRC_LIT = 2'd0;
  localparam logic [1:0] UC_SRC_MAP = 2'd1;

  typedef enum logic {
    DBG_RUN  = 1'b0,
    DBG_HALT = 1'b1
  } dbg_state_t;

  function automatic int csel_width(input int ncond);
    return $clog2(ncond);
  endfunction

  function automatic int ctrl_width(input int word_w, input int addr_w, input int ncond);
    return word_w - addr_w - 6 - csel_width(ncond);
  endfunction

  // Bit positions below are LSB-relative offsets into the microword.
  function automatic int ctrl_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int csel_lsb(input int word_w, input int addr_w, input int ncond);
    return addr_w + ctrl_width(word_w, addr_w, ncond);
  endfunction

  function automatic int pol_bit(input int word_w);
    return word_w - 6;
  endfunction

  function automatic int op_lsb(input int word_w);
    return word_w - 5;
  endfunction

  function automatic int src_lsb(input int word_w);
    return word_w - 2;
  endfunction

endpackage

// File: rtl/uc_return_stack.sv
// Return-address stack for uc_sequencer: LIFO of DEPTH entries, WIDTH bits wide.
// Only the pointer is reset; entry contents survive reset.
module uc_return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SP_W-1:0]  sp;

  assign full  = (sp == SP_W'(DEPTH));
  assign empty = (sp == '0);
  assign top   = empty ? '0 : mem[IDX_W'(sp - SP_W'(1))];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[IDX_W'(sp)] <= din;
    end
  end

endmodule

// File: rtl/uc_sequencer.sv
// Microprogram sequencer: next-address decode, microword pipeline, return stack and loop counter.
// Optional breakpoint/halt support is built when UC_SEQ_BREAKPOINT_EN is defined.
module uc_sequencer
  import uc_seq_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WORD_W      = 40,
  parameter int STACK_DEPTH = 4,
  parameter int NCOND       = 8,
  parameter int CNT_W       = 8
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         hold,
  input  logic [WORD_W-1:0]                            uc_data,
  input  logic [ADDR_W-1:0]                            map_addr,
  input  logic [NCOND-1:0]                             cond,
`ifdef UC_SEQ_BREAKPOINT_EN
  input  logic                                         brk_en,
  input  logic [ADDR_W-1:0]                            brk_addr,
  input  logic                                         resume,
  output logic                                         halted,
`endif
  output logic [ADDR_W-1:0]                            uc_addr,
  output logic [ctrl_width(WORD_W, ADDR_W, NCOND)-1:0] ctrl,
  output logic                                         cnt_zero,
  output logic                                         stack_err
);

  localparam int CSEL_W   = csel_width(NCOND);
  localparam int CTRL_W   = ctrl_width(WORD_W, ADDR_W, NCOND);
  localparam int CTRL_LSB = ctrl_lsb(ADDR_W);
  localparam int CSEL_LSB = csel_lsb(WORD_W, ADDR_W, NCOND);
  localparam int POL_BIT  = pol_bit(WORD_W);
  localparam int OP_LSB   = op_lsb(WORD_W);
  localparam int SRC_LSB  = src_lsb(WORD_W);

  logic [WORD_W-1:0] uword_p1;
  logic [ADDR_W-1:0] upc;
  logic [CNT_W-1:0]  cnt;

  logic [1:0]        src;
  logic [2:0]        op;
  logic              pol;
  logic [CSEL_W-1:0] csel;
  logic [ADDR_W-1:0] lit;
  logic [ADDR_W-1:0] din;
  logic              ct;

  logic [ADDR_W-1:0] next_addr;
  logic              do_push;
  logic              do_pop;
  logic              cnt_load;
  logic              cnt_dec;
  logic              err_set;
  logic              step;

  logic [ADDR_W-1:0] stk_top;
  logic              stk_full;
  logic              stk_empty;

  // Stage p1: decode of the word held in the pipeline register
  assign src  = uword_p1[SRC_LSB +: 2];
  assign op   = uword_p1[OP_LSB +: 3];
  assign pol  = uword_p1[POL_BIT];
  assign csel = uword_p1[CSEL_LSB +: CSEL_W];
  assign lit  = uword_p1[ADDR_W-1:0];
  assign ctrl = uword_p1[CTRL_LSB +: CTRL_W];

  assign din      = (src == UC_SRC_MAP) ? map_addr : lit;
  assign ct       = (csel == '0) ? 1'b1 : (cond[csel] ^ pol);
  assign cnt_zero = (cnt == '0);
  assign uc_addr  = next_addr;

  always_comb begin
    next_addr = upc;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    err_set   = 1'b0;
    case (op)
      UC_CONT: ;
      UC_JUMP: begin
        if (ct) next_addr = din;
      end
      UC_CALL: begin
        // A full stack drops the return address but the branch is still taken.
        if (ct) begin
          next_addr = din;
          if (stk_full) err_set = 1'b1;
          else          do_push = 1'b1;
        end
      end
      UC_RET: begin
        if (ct) begin
          if (stk_empty) begin
            err_set = 1'b1;
          end else begin
            next_addr = stk_top;
            do_pop    = 1'b1;
          end
        end
      end
      UC_LDCT: cnt_load = 1'b1;
      UC_LOOP: begin
        if (!cnt_zero) begin
          next_addr = din;
          cnt_dec   = 1'b1;
        end
      end
      default: ;
    endcase
  end

`ifdef UC_SEQ_BREAKPOINT_EN
  dbg_state_t dbg_state;
  logic       brk_hit;

  assign brk_hit = brk_en && (next_addr == brk_addr) && (dbg_state == DBG_RUN);
  // Resume lets exactly one edge through, moving past the breakpoint address.
  assign step    = !hold && !brk_hit && ((dbg_state == DBG_RUN) || resume);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dbg_state <= DBG_RUN;
      halted    <= 1'b0;
    end else if (!hold) begin
      case (dbg_state)
        DBG_RUN: begin
          if (brk_hit) begin
            dbg_state <= DBG_HALT;
            halted    <= 1'b1;
          end
        end
        DBG_HALT: begin
          if (resume) begin
            dbg_state <= DBG_RUN;
            halted    <= 1'b0;
          end
        end
        default: begin
          dbg_state <= DBG_RUN;
          halted    <= 1'b0;
        end
      endcase
    end
  end
`else
  assign step = !hold;
`endif

  uc_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (do_push && step),
    .pop   (do_pop && step),
    .din   (upc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Stage p0 -> p1: fetch ROM word, advance upc, update counter and error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uword_p1  <= '0;
      upc       <= '0;
      cnt       <= '0;
      stack_err <= 1'b0;
    end else if (step) begin
      uword_p1 <= uc_data;
      upc      <= next_addr + ADDR_W'(1);
      if (cnt_load)     cnt <= lit[CNT_W-1:0];
      else if (cnt_dec) cnt <= cnt - CNT_W'(1);
      if (err_set) stack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed bench for uc_sequencer at default parameters, driving a bench-side CodeROM image.
// Breakpoint checks are compiled in when UC_SEQ_BREAKPOINT_EN is defined.
module tb_uc_sequencer;

  localparam logic [2:0] OP_CONT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_LDCT = 3'd4;
  localparam logic [2:0] OP_LOOP = 3'd5;

  logic        clock = 1'b0;
  logic        reset;
  logic        hold;
  logic [39:0] uc_data;
  logic [11:0] map_addr;
  logic [7:0]  cond;
  logic [11:0] uc_addr;
  logic [18:0] ctrl;
  logic        cnt_zero;
  logic        stack_err;
`ifdef UC_SEQ_BREAKPOINT_EN
  logic        brk_en;
  logic [11:0] brk_addr;
  logic        resume;
  logic        halted;
`endif

  logic [39:0] rom [0:4095];
  int n_assert = 0;
  int n_fail   = 0;

  assign uc_data = rom[uc_addr];
  always #5 clock = ~clock;

  uc_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .hold      (hold),
    .uc_data   (uc_data),
    .map_addr  (map_addr),
    .cond      (cond),
`ifdef UC_SEQ_BREAKPOINT_EN
    .brk_en    (brk_en),
    .brk_addr  (brk_addr),
    .resume    (resume),
    .halted    (halted),
`endif
    .uc_addr   (uc_addr),
    .ctrl      (ctrl),
    .cnt_zero  (cnt_zero),
    .stack_err (stack_err)
  );

  function automatic logic [39:0] mw(input logic [1:0] src, input logic [2:0] op,
                                     input logic pol, input logic [2:0] csel,
                                     input logic [18:0] ctl, input logic [11:0] lit);
    return {src, op, pol, csel, ctl, lit};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = '0;
    rom[12'h000] = mw(2'd0, OP_CONT, 1'b0, 3'd0, 19'h11111, 12'h000);
    rom[12'h001] = mw(2'd0, OP_CONT, 1'b0, 3'd0, 19'h22222, 12'h000);
    rom[12'h002] = mw(2'd0, OP_JUMP, 1'b0, 3'd3, 19'h33333, 12'h100);
    rom[12'h003] = mw(2'd0, OP_JUMP, 1'b0, 3'd0, 19'h00003, 12'h010);
    rom[12'h010] = mw(2'd0, OP_CALL, 1'b0, 3'd0, 19'h00010, 12'h200);
    rom[12'h200] = mw(2'd0, OP_CONT, 1'b0, 3'd0, 19'h0ABCD, 12'h000);
    rom[12'h201] = mw(2'd0, OP_CALL, 1'b0, 3'd0, 19'h05555, 12'h300);
    rom[12'h300] = mw(2'd0, OP_RET,  1'b0, 3'd0, 19'h00300, 12'h000);
    rom[12'h202] = mw(2'd0, OP_RET,  1'b0, 3'd0, 19'h00202, 12'h000);
    rom[12'h011] = mw(2'd0, OP_LDCT, 1'b0, 3'd0, 19'h00011, 12'h003);
    rom[12'h012] = mw(2'd0, OP_LOOP, 1'b0, 3'd0, 19'h00012, 12'h012);
    rom[12'h013] = mw(2'd1, OP_JUMP, 1'b0, 3'd0, 19'h01313, 12'h000);
    rom[12'h0A5] = mw(2'd0, OP_JUMP, 1'b0, 3'd0, 19'h000A5, 12'h020);
    rom[12'h020] = mw(2'd0, OP_CALL, 1'b0, 3'd0, 19'h00020, 12'h040);
    rom[12'h040] = mw(2'd0, OP_CALL, 1'b0, 3'd0, 19'h00040, 12'h050);
    rom[12'h050] = mw(2'd0, OP_CALL, 1'b0, 3'd0, 19'h00050, 12'h060);
    rom[12'h060] = mw(2'd0, OP_CALL, 1'b0, 3'd0, 19'h00060, 12'h070);
    rom[12'h070] = mw(2'd0, OP_CALL, 1'b0, 3'd0, 19'h00070, 12'h080);
    rom[12'h080] = mw(2'd0, OP_RET,  1'b0, 3'd0, 19'h00080, 12'h000);
    rom[12'h061] = mw(2'd0, OP_RET,  1'b0, 3'd0, 19'h00061, 12'h000);
    rom[12'h051] = mw(2'd0, OP_RET,  1'b0, 3'd0, 19'h00051, 12'h000);
    rom[12'h041] = mw(2'd0, OP_RET,  1'b0, 3'd0, 19'h00041, 12'h000);
    rom[12'h021] = mw(2'd0, OP_RET,  1'b0, 3'd0, 19'h00021, 12'h000);

    reset    = 1'b1;
    hold     = 1'b0;
    cond     = 8'h00;
    map_addr = 12'h0A5;
`ifdef UC_SEQ_BREAKPOINT_EN
    brk_en   = 1'b0;
    brk_addr = 12'h0A5;
    resume   = 1'b0;
`endif
    #12;
    chk("reset_uc_addr", 32'(uc_addr), 32'h0);
    chk("reset_ctrl", 32'(ctrl), 32'h0);
    chk("reset_cnt_zero", 32'(cnt_zero), 32'h1);
    chk("reset_stack_err", 32'(stack_err), 32'h0);
`ifdef UC_SEQ_BREAKPOINT_EN
    chk("reset_halted", 32'(halted), 32'h0);
`endif
    @(negedge clock);
    reset = 1'b0;

    tick();
    chk("seq_addr1", 32'(uc_addr), 32'h001);
    chk("seq_ctrl0", 32'(ctrl), 32'h11111);
    tick();
    chk("seq_addr2", 32'(uc_addr), 32'h002);
    chk("seq_ctrl1", 32'(ctrl), 32'h22222);
    tick();
    chk("jump_ctrl", 32'(ctrl), 32'h33333);
    cond = 8'h08;
    #1;
    chk("jump_taken", 32'(uc_addr), 32'h100);
    cond = 8'h00;
    #1;
    chk("jump_not_taken", 32'(uc_addr), 32'h003);

    tick();
    chk("jump_always", 32'(uc_addr), 32'h010);
    tick();
    chk("call1_target", 32'(uc_addr), 32'h200);
    tick();
    chk("cont_in_sub", 32'(uc_addr), 32'h201);
    hold = 1'b1;
    tick();
    chk("hold_addr", 32'(uc_addr), 32'h201);
    chk("hold_ctrl", 32'(ctrl), 32'h0ABCD);
    hold = 1'b0;
    tick();
    chk("call2_target", 32'(uc_addr), 32'h300);
    chk("call2_ctrl", 32'(ctrl), 32'h05555);
    tick();
    chk("ret1_addr", 32'(uc_addr), 32'h202);
    tick();
    chk("ret2_addr", 32'(uc_addr), 32'h011);
    chk("nested_stack_err", 32'(stack_err), 32'h0);

    tick();
    chk("ldct_addr", 32'(uc_addr), 32'h012);
    chk("ldct_cnt_zero", 32'(cnt_zero), 32'h1);
    tick();
    chk("loop1_addr", 32'(uc_addr), 32'h012);
    chk("loop1_cnt_zero", 32'(cnt_zero), 32'h0);
    tick();
    chk("loop2_addr", 32'(uc_addr), 32'h012);
    tick();
    chk("loop3_addr", 32'(uc_addr), 32'h012);
    tick();
    chk("loop_exit_addr", 32'(uc_addr), 32'h013);
    chk("loop_exit_cnt_zero", 32'(cnt_zero), 32'h1);

    tick();
    chk("map_dispatch", 32'(uc_addr), 32'h0A5);
`ifdef UC_SEQ_BREAKPOINT_EN
    brk_en = 1'b1;
    tick();
    chk("brk_halted", 32'(halted), 32'h1);
    chk("brk_addr_held", 32'(uc_addr), 32'h0A5);
    chk("brk_ctrl_held", 32'(ctrl), 32'h01313);
    tick();
    chk("brk_still_halted", 32'(halted), 32'h1);
    chk("brk_addr_held2", 32'(uc_addr), 32'h0A5);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    brk_en = 1'b0;
    chk("resume_halted", 32'(halted), 32'h0);
    chk("resume_addr", 32'(uc_addr), 32'h020);
`else
    tick();
    chk("map_target_jump", 32'(uc_addr), 32'h020);
`endif

    tick();
    chk("ovf_call1", 32'(uc_addr), 32'h040);
    tick();
    chk("ovf_call2", 32'(uc_addr), 32'h050);
    tick();
    chk("ovf_call3", 32'(uc_addr), 32'h060);
    tick();
    chk("ovf_call4", 32'(uc_addr), 32'h070);
    tick();
    chk("ovf_call5_target", 32'(uc_addr), 32'h080);
    chk("ovf_err_before", 32'(stack_err), 32'h0);
    tick();
    chk("ovf_err_after", 32'(stack_err), 32'h1);
    chk("ovf_ret1", 32'(uc_addr), 32'h061);
    tick();
    chk("ovf_ret2", 32'(uc_addr), 32'h051);
    tick();
    chk("ovf_ret3", 32'(uc_addr), 32'h041);
    tick();
    chk("ovf_ret4", 32'(uc_addr), 32'h021);
    tick();
    chk("empty_ret_fallthru", 32'(uc_addr), 32'h022);
    tick();
    chk("empty_ret_err_sticky", 32'(stack_err), 32'h1);
    chk("after_empty_ret_addr", 32'(uc_addr), 32'h023);

    reset = 1'b1;
    #1;
    chk("midreset_uc_addr", 32'(uc_addr), 32'h0);
    chk("midreset_stack_err", 32'(stack_err), 32'h0);
    chk("midreset_ctrl", 32'(ctrl), 32'h0);
    rom[12'h002] = mw(2'd0, OP_JUMP, 1'b1, 3'd3, 19'h33333, 12'h100);
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    tick();
    cond = 8'h08;
    #1;
    chk("pol_cond1", 32'(uc_addr), 32'h003);
    cond = 8'h00;
    #1;
    chk("pol_cond0", 32'(uc_addr), 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_sequencer.md
# uc_sequencer

Parametrised microprogram control unit for the microcoded Sigma datapath. It generates the next microcode ROM address and owns the microcode pipeline register. It provides a conditional next/jump/call/return sequencer, a return stack of configurable depth, a loop counter and an instruction-map dispatch path. It sits between the CodeROM/MapROM pair and the datapath, replacing the fixed 12-bit, two-op sequencing currently embedded in the CPU.

## Interface
- ADDR_W, 12, microcode address width
- WORD_W, 40, microword width
- STACK_DEPTH, 4, return stack entries (≥1)
- NCOND, 8, condition inputs (power of 2); CSEL_W = clog2(NCOND)
- CNT_W, 8, loop counter width (≤ ADDR_W)
- CTRL_W = WORD_W − ADDR_W − 6 − CSEL_W (derived, 19 at defaults)

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- hold  in  1  stall; freezes all state
- uc_data  in  [0:WORD_W-1]  CodeROM output, asynchronous ROM
- map_addr  in  [0:ADDR_W-1]  MapROM dispatch address
- cond  in  [0:NCOND-1]  condition inputs; bit 0 is ignored
- uc_addr  out  [0:ADDR_W-1]  combinational next address, drives CodeROM
- ctrl  out  [0:CTRL_W-1]  pipeline control field to datapath
- cnt_zero  out  1  loop counter == 0
- stack_err  out  1  sticky overflow/underflow flag

## Operation
- Microword fields, MSB-first:
  - [0:1] src: 0 = literal, 1 = map_addr, 2/3 = literal
  - [2:4] op
  - [5] pol
  - [6:6+CSEL_W-1] csel
  - then ctrl
  - last ADDR_W bits: literal
- din = selected src. ct = (csel == 0) ? 1 : cond[csel] ^ pol.
- op 0 CONT: uc_addr = upc.
- op 1 JUMP: ct ? din : upc.
- op 2 CALL: if ct, push upc and uc_addr = din; else upc.
- op 3 RET: if ct, uc_addr = top and pop; else upc.
- op 4 LDCT: cnt ← low CNT_W bits of literal; uc_addr = upc. Condition is ignored.
- op 5 LOOP: if cnt ≠ 0, cnt ← cnt − 1 and uc_addr = din; else uc_addr = upc. Condition is ignored.
- ops 6, 7 are reserved and behave as CONT.
- Each unstalled edge: pipeline ← uc_data; upc ← uc_addr + 1 (wraps mod 2^ADDR_W).
- Stack full on CALL: the push is discarded, the jump is still taken, and stack_err is set.
- Stack empty on RET with ct: uc_addr = upc, sp stays 0, and stack_err is set.
- stack_err clears only on reset.

## Timing
- Reset values:
  - pipeline, upc, sp, cnt = 0
  - uc_addr = 0, ctrl = 0, cnt_zero = 1, stack_err = 0
- After reset is released, the first edge fetches word 0. uc_addr is valid in the same cycle the pipeline holds the word.
- Zero-latency decode: uc_addr depends combinationally on pipeline, cond, map_addr, upc, stack top and cnt.
- One-cycle latency: ROM word to ctrl.
- hold = 1: pipeline, upc, sp, stack, cnt and stack_err are unchanged. uc_addr reflects the held state.
- Reset asserted mid-operation clears all state asynchronously. The stack contents themselves are not cleared.

## Configuration
- UC_SEQ_BREAKPOINT_EN defined: adds the following.
  - Ports: brk_en (in, 1), brk_addr (in, ADDR_W), resume (in, 1 pulse), halted (out, 1, reset 0).
  - When brk_en and uc_addr == brk_addr and not halted: that edge sets halted and does not advance state.
  - While halted, behaviour is identical to hold.
  - resume while halted: the next edge clears halted and advances exactly once, past the breakpoint.
- Undefined: the ports above are absent and behaviour is unchanged.

## Structure
- Package uc_seq_pkg:
  - op localparams (UC_CONT … UC_LOOP)
  - src encodings
  - field-offset functions of WORD_W/ADDR_W/NCOND
- Sub-module uc_return_stack, parametrised depth/width:
  - push/pop/top/full/empty outputs
  - push and pop in the same cycle never occurs

## Test plan
- Reset with word 0 = CONT: uc_addr sequence 0, 1, 2, 3 on successive edges; ctrl equals each word's field one cycle after fetch.
- JUMP at addr 2 to 0x100, csel 3, pol 0:
  - cond[3] = 1 → next fetch is 0x100.
  - cond[3] = 0 → next fetch is 3.
  - pol = 1 inverts both outcomes.
- Nested CALL 0x10→0x200, 0x201→0x300, then RET, RET: fetches are 0x300, then 0x202, then 0x11; stack_err = 0.
- STACK_DEPTH = 4:
  - Five nested CALLs: stack_err = 1 after the fifth call, and the fifth target is still fetched.
  - RET on an empty stack: falls through to upc and stack_err stays 1.
- LDCT 3, then LOOP to self: the LOOP word is executed 4 times, 3 branches then fall-through; cnt_zero = 1 on exit.
- src = 1 JUMP with map_addr = 0x0A5: fetches 0x0A5. Under UC_SEQ_BREAKPOINT_EN with brk_addr = 0x0A5: halted = 1, and uc_addr is held at 0x0A5 until resume.
